// File: rtl/robm_seq_ctrl.sv
// Mealy sequence controller S1..S7 with an optional dwell watchdog on the S4/S7 wait states.
// Define ROBM_WATCHDOG_EN to compile in the dwell counter and timeout abort; otherwise timeout stays 0.
module robm_seq_ctrl #(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [12:1]      x,
  output logic [10:1]      y,
  output logic [2:0]       state,
  output logic             timeout,
  output logic [CNT_W-1:0] cyc_cnt
);

  typedef enum logic [2:0] {
    S_ILL = 3'd0,
    S1    = 3'd1,
    S2    = 3'd2,
    S3    = 3'd3,
    S4    = 3'd4,
    S5    = 3'd5,
    S6    = 3'd6,
    S7    = 3'd7
  } state_t;

  if (WAIT_MAX < 2 || WAIT_MAX > 65536) begin : gBadWaitMax
    $error("robm_seq_ctrl: WAIT_MAX must be in 2..65536");
  end

  state_t           state_q, state_d;
  logic [10:1]      cmd;
  logic             abort;
  logic             atLimit;
  logic             timeout_q;
  logic [CNT_W-1:0] cyc_q;

`ifdef ROBM_WATCHDOG_EN
  localparam int DW = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;
  localparam logic [DW-1:0] DWELL_LIM = DW'(WAIT_MAX - 1);
  logic [DW-1:0] dwell_q;
  assign atLimit = (dwell_q == DWELL_LIM);
`else
  assign atLimit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cmd     = '0;
    abort   = 1'b0;
    if (en) begin
      case (state_q)
        S1: begin
          if (x[1]) begin
            if (x[11]) begin
              if (x[12]) begin
                cmd[4]  = 1'b1;
                state_d = S2;
              end else begin
                cmd[7]  = 1'b1;
                cmd[8]  = 1'b1;
                state_d = S3;
              end
            end else if (x[12]) begin
              if (x[8]) begin
                cmd[1]  = 1'b1;
                cmd[2]  = 1'b1;
                state_d = S4;
              end else if (x[5]) begin
                cmd[2]  = 1'b1;
                cmd[3]  = 1'b1;
                state_d = S4;
              end else if (x[6]) begin
                cmd[10] = 1'b1;
                state_d = S5;
              end else begin
                cmd[4]  = 1'b1;
                state_d = S2;
              end
            end else begin
              case ({x[10], x[9]})
                2'b11: begin
                  cmd[10] = 1'b1;
                  state_d = S5;
                end
                2'b10: begin
                  cmd[1]  = 1'b1;
                  cmd[2]  = 1'b1;
                  state_d = S4;
                end
                2'b01: begin
                  cmd[2]  = 1'b1;
                  cmd[3]  = 1'b1;
                  state_d = S4;
                end
                default: begin
                  cmd[4]  = 1'b1;
                  state_d = S2;
                end
              endcase
            end
          end
        end
        S2: begin
          cmd[5]  = 1'b1;
          state_d = S1;
        end
        S3: begin
          cmd[6]  = 1'b1;
          state_d = S6;
        end
        S4: begin
          if (x[4]) begin
            cmd[4]  = 1'b1;
            state_d = S2;
          end else if (atLimit) begin
            abort   = 1'b1;
            state_d = S1;
          end
        end
        S5: begin
          cmd[2] = 1'b1;
          if (x[12]) begin
            cmd[9]  = 1'b1;
            state_d = S7;
          end else begin
            cmd[3]  = 1'b1;
            state_d = S4;
          end
        end
        S6: begin
          if (x[2]) begin
            cmd[2]  = 1'b1;
            cmd[1]  = x[3];
            cmd[3]  = ~x[3];
            state_d = S4;
          end else begin
            cmd[4]  = 1'b1;
            state_d = S2;
          end
        end
        S7: begin
          if (x[7]) begin
            cmd[2]  = 1'b1;
            cmd[3]  = 1'b1;
            state_d = S4;
          end else if (atLimit) begin
            abort   = 1'b1;
            state_d = S1;
          end
        end
        default: state_d = S1;
      endcase
    end
  end

  // Dwell count restarts whenever the state changes, so an abort also clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S1;
      timeout_q <= 1'b0;
      cyc_q     <= '0;
`ifdef ROBM_WATCHDOG_EN
      dwell_q   <= '0;
`endif
    end else begin
      timeout_q <= abort;
      if (en) begin
        state_q <= state_d;
        if (state_q == S2 && state_d == S1 && cyc_q != {CNT_W{1'b1}})
          cyc_q <= cyc_q + 1'b1;
`ifdef ROBM_WATCHDOG_EN
        if (state_d == state_q && (state_q == S4 || state_q == S7))
          dwell_q <= dwell_q + 1'b1;
        else
          dwell_q <= '0;
`endif
      end
    end
  end

  assign y       = cmd;
  assign state   = state_q;
  assign timeout = timeout_q;
  assign cyc_cnt = cyc_q;

endmodule

// File: tb/tb_robm_seq_ctrl.sv
// Self-checking bench for robm_seq_ctrl: rule-level reference model, directed scenarios, then random stimulus.
// Model follows ROBM_WATCHDOG_EN the same way the design build does.
module tb_robm_seq_ctrl;

  localparam int WM = 16;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [12:1]   x;
  logic [10:1]   y;
  logic [2:0]    state;
  logic          timeout;
  logic [CW-1:0] cyc_cnt;

  int errors = 0;
  int checks = 0;

  int  mState;
  int  mDwell;
  int  mCyc;
  bit  mTo;
  logic [10:1] lastY;

  robm_seq_ctrl #(.WAIT_MAX(WM), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .x(x),
    .y(y), .state(state), .timeout(timeout), .cyc_cnt(cyc_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [10:1] yb(input int a, input int b = 0);
    logic [10:1] v;
    v = '0;
    v[a] = 1'b1;
    if (b != 0) v[b] = 1'b1;
    return v;
  endfunction

  function automatic logic [12:1] xbits(input int a = 0, input int b = 0, input int c = 0);
    logic [12:1] v;
    v = '0;
    if (a != 0) v[a] = 1'b1;
    if (b != 0) v[b] = 1'b1;
    if (c != 0) v[c] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Rule table of the controller: command bits and successor, before any watchdog override.
  function automatic void modelComb(input int s, input logic [12:1] xv, input logic ev,
                                    output logic [10:1] ye, output int ns);
    int code;
    ye = '0;
    ns = s;
    if (!ev) return;
    case (s)
      1: if (xv[1]) begin
        if (xv[11]) begin
          if (xv[12]) begin ye = yb(4); ns = 2; end
          else begin ye = yb(7, 8); ns = 3; end
        end else if (xv[12]) begin
          if (xv[8])      begin ye = yb(1, 2); ns = 4; end
          else if (xv[5]) begin ye = yb(2, 3); ns = 4; end
          else if (xv[6]) begin ye = yb(10);   ns = 5; end
          else            begin ye = yb(4);    ns = 2; end
        end else begin
          code = 2 * int'(xv[10]) + int'(xv[9]);
          if (code == 3)      begin ye = yb(10);   ns = 5; end
          else if (code == 2) begin ye = yb(1, 2); ns = 4; end
          else if (code == 1) begin ye = yb(2, 3); ns = 4; end
          else                begin ye = yb(4);    ns = 2; end
        end
      end
      2: begin ye = yb(5); ns = 1; end
      3: begin ye = yb(6); ns = 6; end
      4: if (xv[4]) begin ye = yb(4); ns = 2; end
      5: if (xv[12]) begin ye = yb(2, 9); ns = 7; end
         else begin ye = yb(2, 3); ns = 4; end
      6: if (!xv[2]) begin ye = yb(4); ns = 2; end
         else if (xv[3]) begin ye = yb(1, 2); ns = 4; end
         else begin ye = yb(2, 3); ns = 4; end
      7: if (xv[7]) begin ye = yb(2, 3); ns = 4; end
      default: ns = 1;
    endcase
  endfunction

  task automatic modelReset();
    mState = 1;
    mDwell = 0;
    mCyc   = 0;
    mTo    = 1'b0;
  endtask

  // Called at a falling edge: drive, compare all outputs, advance model across the rising edge.
  task automatic step(input logic ev, input logic [12:1] xv);
    logic [10:1] ye;
    int ns;
    bit abortE;
    en = ev;
    x  = xv;
    #1;
    modelComb(mState, xv, ev, ye, ns);
    abortE = 1'b0;
`ifdef ROBM_WATCHDOG_EN
    if (ev && ns == mState && (mState == 4 || mState == 7) && mDwell == WM - 1) begin
      ns = 1;
      abortE = 1'b1;
    end
`endif
    chk("y", y, ye);
    chk("state", state, mState);
    chk("timeout", timeout, mTo);
    chk("cyc_cnt", cyc_cnt, mCyc);
    lastY = y;
    @(posedge clk);
    if (rst) begin
      modelReset();
    end else if (ev) begin
      if (mState == 2 && ns == 1 && mCyc < (1 << CW) - 1) mCyc++;
      if (ns != mState) mDwell = 0;
      else if (mState == 4 || mState == 7) mDwell++;
      else mDwell = 0;
      mState = ns;
      mTo = abortE;
    end else begin
      mTo = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic asyncReset();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_state", state, 1);
    chk("async_rst_cyc", cyc_cnt, 0);
    chk("async_rst_timeout", timeout, 0);
    modelReset();
    @(negedge clk);
    step(1'b0, '0);
    rst = 1'b0;
  endtask

  initial begin
    int expHold;
    logic ev;
    logic [12:1] xv;
    rst = 1'b1;
    en  = 1'b0;
    x   = '0;
    modelReset();
    @(negedge clk);
    step(1'b0, '0);
    step(1'b1, xbits(1, 11, 12));
    chk("rst_state", state, 1);
    rst = 1'b0;

    // Short loop S1 -> S2 -> S1
    step(1'b1, xbits(1, 11, 12));
    chk("lit_y4", lastY, 10'h008);
    step(1'b1, '0);
    chk("lit_y5", lastY, 10'h010);
    chk("lit_cyc1", cyc_cnt, 1);

    // S1 -> S5 -> S7 -> S4 -> S2 -> S1
    step(1'b1, xbits(1, 12, 6));
    chk("lit_y10", lastY, 10'h200);
    step(1'b1, xbits(12));
    chk("lit_y2y9", lastY, 10'h102);
    step(1'b1, xbits(7));
    chk("lit_s7_exit", lastY, 10'h006);
    step(1'b1, xbits(4));
    chk("lit_s4_exit", lastY, 10'h008);
    step(1'b1, '0);
    chk("lit_cyc2", cyc_cnt, 2);

    // S1 -> S3 -> S6 -> S4, then hold in S4
    step(1'b1, xbits(1, 11));
    chk("lit_y7y8", lastY, 10'h0C0);
    step(1'b1, '0);
    chk("lit_y6", lastY, 10'h020);
    step(1'b1, xbits(2));
    chk("lit_s6_y2y3", lastY, 10'h006);
    repeat (20) step(1'b1, '0);
`ifdef ROBM_WATCHDOG_EN
    expHold = 1;
`else
    expHold = 4;
`endif
    chk("lit_s4_hold", state, expHold);

    // Gated wait in S7
    step(1'b1, xbits(4));
    step(1'b1, '0);
    step(1'b1, xbits(1, 12, 6));
    step(1'b1, xbits(12));
    repeat (3) step(1'b1, '0);
    repeat (5) step(1'b0, '0);
    repeat (20) step(1'b1, '0);
    step(1'b1, xbits(7));
    step(1'b1, xbits(4));
    step(1'b1, '0);

    // Saturation of the 2-bit cycle counter
    repeat (5) begin
      step(1'b1, xbits(1, 11, 12));
      step(1'b1, '0);
    end
    chk("lit_sat", cyc_cnt, 3);

    // Asynchronous reset while waiting in S4
    step(1'b1, xbits(1, 10));
    repeat (3) step(1'b1, '0);
    asyncReset();

    // Long S4 hold
    step(1'b1, xbits(1, 10));
    repeat (100) step(1'b1, '0);

    for (int i = 0; i < 3000; i++) begin
      ev = ($urandom_range(7) != 0);
      xv = 12'($urandom);
      xv[4] = ($urandom_range(5) == 0);
      xv[7] = ($urandom_range(5) == 0);
      if ($urandom_range(600) == 0) asyncReset();
      else step(ev, xv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/robm_seq_ctrl.md
ROBM_SEQ_CTRL -- requirements
Module: robm_seq_ctrl

Interface
REQ-001 Parameter WAIT_MAX, default 16, meaning dwell-cycle limit in wait states S4/S7 (legal 2..2^16).
REQ-002 Parameter CNT_W, default 8, meaning width of completed-cycle counter.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  step enable; 0 = hold state, force y to 0.
REQ-006 x  input  12  condition inputs x[12:1] (bit n = xn).
REQ-007 y  output  10  Mealy command outputs y[10:1] (bit n = yn), combinational from state, x, en.
REQ-008 state  output  3  current state code, S1..S7 = 1..7.
REQ-009 timeout  output  1  registered one-cycle pulse on watchdog abort.
REQ-010 cyc_cnt  output  CNT_W  count of completed cycles, saturating.

Function
REQ-011 Unlisted y bits SHALL be 0; transitions SHALL occur only on a rising edge with en=1.
REQ-012 S1: ~x1 -> stay S1, y=0.
REQ-013 S1, x1&x11: x12 -> y4, S2; ~x12 -> y7,y8, S3.
REQ-014 S1, x1&~x11&x12, priority order: x8 -> y1,y2, S4; x5 -> y2,y3, S4; x6 -> y10, S5; else y4, S2.
REQ-015 S1, x1&~x11&~x12 by {x10,x9}: 11 -> y10, S5; 10 -> y1,y2, S4; 01 -> y2,y3, S4; 00 -> y4, S2.
REQ-016 S2: y5, -> S1 unconditionally.
REQ-017 S3: y6, -> S6 unconditionally.
REQ-018 S4: x4 -> y4, S2; else stay, y=0.
REQ-019 S5: x12 -> y2,y9, S7; ~x12 -> y2,y3, S4.
REQ-020 S6: x2&x3 -> y1,y2, S4; x2&~x3 -> y2,y3, S4; ~x2 -> y4, S2.
REQ-021 S7: x7 -> y2,y3, S4; else stay, y=0.
REQ-022 Illegal state code (0) SHALL drive y=0 and return to S1 next enabled edge.
REQ-023 Dwell counter SHALL clear on any state change and increment each enabled edge spent in S4 or S7 without exit; en=0 freezes it.
REQ-024 When dwell counter equals WAIT_MAX-1 and the exit condition is false on an enabled edge, FSM SHALL go to S1, y=0 that cycle, timeout pulses high the following cycle.
REQ-025 Exit condition true on the limit edge SHALL take the normal transition, no timeout.
REQ-026 cyc_cnt SHALL increment on each S2->S1 transition, saturate at 2^CNT_W-1, never wrap; watchdog abort does not count.
REQ-027 y SHALL be 0 whenever en=0, regardless of state or x.

Reset
REQ-028 rst=1 SHALL immediately force state=S1, dwell counter=0, timeout=0, cyc_cnt=0, independent of clk.
REQ-029 During reset y SHALL be 0 only through S1 decoding (x1=0 -> 0); reset mid-wait SHALL discard dwell count.
REQ-030 First transition after rst deassert SHALL occur on the first rising edge with en=1.

Configuration
REQ-031 Macro ROBM_WATCHDOG_EN defined: REQ-023..REQ-025 watchdog compiled in.
REQ-032 Macro ROBM_WATCHDOG_EN undefined: no dwell counter, S4/S7 wait indefinitely, timeout tied 0; all other behaviour identical.

Verification
REQ-033 Reset, x1=1,x11=1,x12=1 -> y=0x008 (y4), next state S2, y=0x010 (y5), then S1, cyc_cnt=1.
REQ-034 S1 x1=1,x11=0,x12=1,x8=0,x5=0,x6=1 -> y10, S5; x12=1 -> y2,y9, S7; x7=1 -> y2,y3, S4; x4=1 -> S2.
REQ-035 Path S1->S3->S6 with x2=1,x3=0 -> y6 then y2,y3 and S4; hold x4=0 with WAIT_MAX=16 -> abort to S1 after 16 edges in S4, timeout high exactly one cycle.
REQ-036 In S7 with x7=0, toggle en=0 for 5 cycles -> state held, y=0, dwell frozen; timeout occurs 5 cycles later than without gating.
REQ-037 CNT_W=2, run 5 S1->S2->S1 loops -> cyc_cnt sticks at 3.
REQ-038 Assert rst asynchronously mid-S4 between edges -> state=1, cyc_cnt=0 immediately; build without ROBM_WATCHDOG_EN -> S4 held 100 cycles, timeout stays 0.
